// File: rtl/fft_dif_sequencer_pkg.sv
// Shared constants for the radix-2 DIF FFT control slice: default sizes,
// sequencer state encodings and butterfly control bit positions.
package fft_dif_sequencer_pkg;

    localparam int FFT_N_DEF  = 10;
    localparam int FFT_DW_DEF = 16;
    localparam int BF_LATENCY = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int ICTRL_FIRST = 0;
    localparam int ICTRL_LAST  = 1;

endpackage

// File: rtl/fft_dif_sequencer_if.sv
// Bundle between the FFT sequencer and its environment (sample RAM,
// twiddle ROM, butterfly). The master side is the sequencer.
interface fft_dif_sequencer_if #(
    parameter int FFT_N = 10
);
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [FFT_N-1:0] rd_addr_a;
    logic [FFT_N-1:0] rd_addr_b;
    logic [FFT_N-2:0] tw_addr;
    logic             bf_iact;
    logic [1:0]       bf_ictrl;
    logic [FFT_N-2:0] bf_iaddr;
    logic             bf_oact;
    logic [FFT_N-2:0] bf_oaddr;
    logic             wr_en;
    logic [FFT_N-1:0] wr_addr_a;
    logic [FFT_N-1:0] wr_addr_b;

    modport master (
        input  start, bf_oact, bf_oaddr,
        output busy, done, err, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_iact, bf_ictrl, bf_iaddr, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, bf_oact, bf_oaddr,
        input  busy, done, err, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_iact, bf_ictrl, bf_iaddr, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_dif_sequencer_addr_gen.sv
// In-place DIF addressing: maps (stage, butterfly index) to the two wing
// sample addresses and the twiddle ROM index. Purely combinational.
module fft_dif_addr_gen
    import fft_dif_sequencer_pkg::*;
#(
    parameter int FFT_N = FFT_N_DEF,
    parameter int SW    = $clog2(FFT_N + 1)
) (
    input  logic [SW-1:0]    i_stage,
    input  logic [FFT_N-2:0] i_k,
    output logic [FFT_N-1:0] o_addr_a,
    output logic [FFT_N-1:0] o_addr_b,
    output logic [FFT_N-2:0] o_tw_addr
);
    logic [SW-1:0]    w_sh;
    logic [SW-1:0]    w_sh1;
    logic [FFT_N-1:0] w_span;
    logic [FFT_N-2:0] w_mask;
    logic [FFT_N-2:0] w_j;
    logic [FFT_N-2:0] w_grp;

    // span = N >> (s+1) = 1 << (FFT_N-1-s); j is k's offset inside its group
    assign w_sh   = SW'(FFT_N - 1) - i_stage;
    assign w_sh1  = w_sh + SW'(1);
    assign w_span = {{(FFT_N-1){1'b0}}, 1'b1} << w_sh;
    assign w_mask = ~({(FFT_N-1){1'b1}} << w_sh);
    assign w_j    = i_k & w_mask;
    assign w_grp  = i_k >> w_sh;

    assign o_addr_a  = ({1'b0, w_grp} << w_sh1) | {1'b0, w_j};
    assign o_addr_b  = o_addr_a + w_span;
    assign o_tw_addr = w_j << i_stage;

endmodule

// File: rtl/fft_dif_sequencer.sv
// Control/address stage ahead of the radix-2 DIF butterfly. Walks FFT_N
// stages of N/2 butterflies, issues RAM/ROM reads, aligns butterfly
// inputs with read data and turns butterfly results into write-backs.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one read per cycle, k = 0 .. N/2-1
// DRAIN | wait until every issued butterfly has been written back
// DONE  | one-cycle done pulse, then IDLE
module fft_dif_sequencer
    import fft_dif_sequencer_pkg::*;
#(
    parameter int FFT_N  = FFT_N_DEF,
    parameter int RD_LAT = 1
) (
    input logic                 clk,
    input logic                 reset,
    fft_dif_sequencer_if.master bus
);
    localparam int SW = $clog2(FFT_N + 1);
    localparam int KW = FFT_N - 1;
    localparam logic [SW-1:0] S_LAST = SW'(FFT_N - 1);
    localparam logic [KW-1:0] K_LAST = '1;

    logic [1:0]       r_state;
    logic [SW-1:0]    r_stage;
    logic [KW-1:0]    r_k;
    logic             r_rd_en;
    logic [FFT_N-1:0] r_rd_addr_a;
    logic [FFT_N-1:0] r_rd_addr_b;
    logic [KW-1:0]    r_tw;
    logic [KW-1:0]    r_rd_k;
    logic [1:0]       r_rd_ctrl;
    logic [FFT_N-1:0] r_outst;
    logic             r_err;

    logic             r_pipe_en   [RD_LAT];
    logic [1:0]       r_pipe_ctrl [RD_LAT];
    logic [KW-1:0]    r_pipe_k    [RD_LAT];

    logic [FFT_N-1:0] w_rd_a;
    logic [FFT_N-1:0] w_rd_b;
    logic [KW-1:0]    w_rd_tw;
    logic [FFT_N-1:0] w_wr_a;
    logic [FFT_N-1:0] w_wr_b;
    logic [KW-1:0]    w_wr_tw;
    logic             w_unused_wr_tw;
    logic             w_oact_ok;

    fft_dif_addr_gen #(.FFT_N(FFT_N), .SW(SW)) u_rd_addr (
        .i_stage   (r_stage),
        .i_k       (r_k),
        .o_addr_a  (w_rd_a),
        .o_addr_b  (w_rd_b),
        .o_tw_addr (w_rd_tw)
    );

    // Write-back uses the current stage: it cannot advance while writes are pending.
    fft_dif_addr_gen #(.FFT_N(FFT_N), .SW(SW)) u_wr_addr (
        .i_stage   (r_stage),
        .i_k       (bus.bf_oaddr),
        .o_addr_a  (w_wr_a),
        .o_addr_b  (w_wr_b),
        .o_tw_addr (w_wr_tw)
    );

    // write side only needs sample addresses
    assign w_unused_wr_tw = ^w_wr_tw;

    // A result is legitimate only when something is actually in flight.
    assign w_oact_ok = bus.bf_oact && (r_outst != '0) && (r_state != ST_IDLE);

    // Stage/k walk and registered read issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_stage     <= '0;
            r_k         <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw        <= '0;
            r_rd_k      <= '0;
            r_rd_ctrl   <= '0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_ISSUE;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_rd_en                <= 1'b1;
                    r_rd_addr_a            <= w_rd_a;
                    r_rd_addr_b            <= w_rd_b;
                    r_tw                   <= w_rd_tw;
                    r_rd_k                 <= r_k;
                    r_rd_ctrl[ICTRL_FIRST] <= (r_k == '0);
                    r_rd_ctrl[ICTRL_LAST]  <= (r_stage == S_LAST) && (r_k == K_LAST);
                    r_k                    <= r_k + KW'(1);
                    if (r_k == K_LAST) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // the last read of the stage is still on r_rd_en in the first DRAIN cycle
                    if ((r_outst == '0) && !r_rd_en) begin
                        if (r_stage == S_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                            r_k     <= '0;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Delay read strobe/ctrl/k so the butterfly sees them with the RAM/ROM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_en[i]   <= 1'b0;
                r_pipe_ctrl[i] <= '0;
                r_pipe_k[i]    <= '0;
            end
        end else begin
            r_pipe_en[0]   <= r_rd_en;
            r_pipe_ctrl[0] <= r_rd_ctrl & {2{r_rd_en}};
            r_pipe_k[0]    <= r_rd_k;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_en[i]   <= r_pipe_en[i-1];
                r_pipe_ctrl[i] <= r_pipe_ctrl[i-1];
                r_pipe_k[i]    <= r_pipe_k[i-1];
            end
        end
    end

    // Butterflies in flight; a stray result flags err and is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            case ({r_rd_en, w_oact_ok})
                2'b10:   r_outst <= r_outst + FFT_N'(1);
                2'b01:   r_outst <= r_outst - FFT_N'(1);
                default: r_outst <= r_outst;
            endcase
            if (bus.bf_oact && !w_oact_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.err       = r_err;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.tw_addr   = r_tw;
    assign bus.bf_iact   = r_pipe_en[RD_LAT-1];
    assign bus.bf_ictrl  = r_pipe_ctrl[RD_LAT-1];
    assign bus.bf_iaddr  = r_pipe_k[RD_LAT-1];
    assign bus.wr_en     = bus.bf_oact;
    assign bus.wr_addr_a = w_wr_a;
    assign bus.wr_addr_b = w_wr_b;

endmodule
